// File: rtl/serializer.sv
`timescale 1ns/1ps
// Parallel-to-serial transmitter: LSB-first frames strobed by write_out, separated by GAP_CYCLES idle cycles.
// Optional build macro SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
module serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clock_1MHz,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  output logic                  ack_out,
  output logic                  serial_out,
  output logic                  write_out,
  output logic                  busy_out,
  output logic [7:0]            frames_out
);

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME_BITS = DATA_WIDTH + 1;
`else
  localparam int FRAME_BITS = DATA_WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shift_reg, shifted;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic [GAP_W-1:0]      gap_cnt, gap_cnt_nxt;
  logic [7:0]            frames_nxt;
  logic                  serial_nxt, write_nxt, ack_nxt, busy_nxt;
  logic                  load, idle_edge, next_bit;

  // shift_reg keeps the whole byte; bit_cnt selects the bit, which also leaves it available for parity.
  assign shifted = shift_reg >> bit_cnt;

`ifdef SERIALIZER_PARITY_EN
  assign next_bit = (bit_cnt == CNT_W'(DATA_WIDTH)) ? ^shift_reg : shifted[0];
`else
  assign next_bit = shifted[0];
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    frames_nxt  = frames_out;
    busy_nxt    = busy_out;
    serial_nxt  = 1'b0;
    write_nxt   = 1'b0;
    ack_nxt     = 1'b0;
    load        = 1'b0;
    idle_edge   = 1'b0;

    unique case (state)
      IDLE: idle_edge = 1'b1;
      SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
          frames_nxt  = frames_out + 8'd1;
        end else begin
          serial_nxt  = next_bit;
          write_nxt   = 1'b1;
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        gap_cnt_nxt = gap_cnt + GAP_W'(1);
        if (gap_cnt == GAP_LAST) idle_edge = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // The final GAP edge behaves exactly like an IDLE edge, giving back-to-back frames.
    if (idle_edge) begin
      if (data_valid_in) begin
        load        = 1'b1;
        serial_nxt  = data_in[0];
        write_nxt   = 1'b1;
        ack_nxt     = 1'b1;
        busy_nxt    = 1'b1;
        bit_cnt_nxt = CNT_W'(1);
        state_nxt   = SHIFT;
      end else begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_1MHz) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      frames_out <= 8'd0;
      serial_out <= 1'b0;
      write_out  <= 1'b0;
      ack_out    <= 1'b0;
      busy_out   <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      frames_out <= frames_nxt;
      serial_out <= serial_nxt;
      write_out  <= write_nxt;
      ack_out    <= ack_nxt;
      busy_out   <= busy_nxt;
    end
  end

  // NOTE: the data register is never read before a load, so it carries no reset.
  always_ff @(posedge clock_1MHz) begin
    if (load) shift_reg <= data_in;
  end

endmodule

// File: tb/tb_serializer.sv
`timescale 1ns/1ps
// Directed bench for serializer: reset, single frame, back-to-back, mid-frame reset,
// ignored valid during a frame, frame counter wrap and parity (when SERIALIZER_PARITY_EN is set).
module tb_serializer;

  localparam int DW  = 8;
  localparam int GAP = 1;
`ifdef SERIALIZER_PARITY_EN
  localparam int FB = DW + 1;
`else
  localparam int FB = DW;
`endif

  logic          clock_1MHz = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          data_valid_in;
  logic          ack_out, serial_out, write_out, busy_out;
  logic [7:0]    frames_out;

  int checks = 0;
  int passes = 0;

  serializer #(.DATA_WIDTH(DW), .GAP_CYCLES(GAP)) dut (
    .clock_1MHz   (clock_1MHz),
    .reset        (reset),
    .data_in      (data_in),
    .data_valid_in(data_valid_in),
    .ack_out      (ack_out),
    .serial_out   (serial_out),
    .write_out    (write_out),
    .busy_out     (busy_out),
    .frames_out   (frames_out)
  );

  always #500 clock_1MHz = ~clock_1MHz;

  // Bit i of a frame carrying byte b: data bits LSB first, then even parity.
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    logic [7:0] s;
    if (i >= DW) return ^b;
    s = b >> i;
    return s[0];
  endfunction

  task automatic do_reset();
    @(negedge clock_1MHz);
    reset = 1'b0;
    data_valid_in = 1'b0;
    @(negedge clock_1MHz);
    reset = 1'b1;
  endtask

  // Waits for ack, then checks every frame bit and the first gap cycle. At the ack cycle the
  // producer moves to next_valid/next_data; at frame bit inj_bit it raises valid with inj_data.
  task automatic expect_frame(input string name, input logic [7:0] b,
                              input logic next_valid, input logic [7:0] next_data,
                              input int inj_bit, input logic [7:0] inj_data,
                              output int waits);
    waits = 0;
    do begin
      @(negedge clock_1MHz);
      waits++;
    end while (ack_out !== 1'b1 && waits < 40);
    checks++;
    if (ack_out !== 1'b1) begin
      $display("FAIL %s_ack: ack_out=%b after %0d cycles, required 1", name, ack_out, waits);
      return;
    end
    passes++;
    data_valid_in = next_valid;
    data_in = next_data;
    for (int i = 0; i < FB; i++) begin
      if (i > 0) @(negedge clock_1MHz);
      checks++;
      if (write_out !== 1'b1 || serial_out !== exp_bit(b, i) || ack_out !== (i == 0) || busy_out !== 1'b1)
        $display("FAIL %s_bit%0d: write/serial/ack/busy=%b%b%b%b required 1%b%b1",
                 name, i, write_out, serial_out, ack_out, busy_out, exp_bit(b, i), (i == 0));
      else passes++;
      if (i == inj_bit) begin
        data_valid_in = 1'b1;
        data_in = inj_data;
      end
    end
    @(negedge clock_1MHz);
    checks++;
    if (write_out !== 1'b0 || serial_out !== 1'b0 || ack_out !== 1'b0)
      $display("FAIL %s_gap: write/serial/ack=%b%b%b required 000", name, write_out, serial_out, ack_out);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    data_valid_in = 1'b1;
    data_in = 8'hA3;
    repeat (5) begin
      @(negedge clock_1MHz);
      checks++;
      if ({ack_out, serial_out, write_out, busy_out, frames_out} !== 12'h000)
        $display("FAIL reset_hold: ack/serial/write/busy=%b%b%b%b frames=%0d required 0000 0",
                 ack_out, serial_out, write_out, busy_out, frames_out);
      else passes++;
    end
    reset = 1'b1;
    data_valid_in = 1'b0;
    repeat (3) begin
      @(negedge clock_1MHz);
      checks++;
      if ({ack_out, serial_out, write_out, busy_out, frames_out} !== 12'h000)
        $display("FAIL reset_idle: ack/serial/write/busy=%b%b%b%b frames=%0d required 0000 0",
                 ack_out, serial_out, write_out, busy_out, frames_out);
      else passes++;
    end
  endtask

  task automatic test_single();
    int w;
    do_reset();
    data_in = 8'hA3;
    data_valid_in = 1'b1;
    expect_frame("single", 8'hA3, 1'b0, 8'h00, -1, 8'h00, w);
    checks++;
    if (frames_out !== 8'd1 || busy_out !== 1'b1)
      $display("FAIL single_gapstate: frames=%0d busy=%b required 1 1", frames_out, busy_out);
    else passes++;
    @(negedge clock_1MHz);
    checks++;
    if (busy_out !== 1'b0 || write_out !== 1'b0 || frames_out !== 8'd1)
      $display("FAIL single_idle: busy=%b write=%b frames=%0d required 0 0 1", busy_out, write_out, frames_out);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int w;
    do_reset();
    data_in = 8'hA3;
    data_valid_in = 1'b1;
    expect_frame("b2b_a3", 8'hA3, 1'b1, 8'h5C, -1, 8'h00, w);
    expect_frame("b2b_5c", 8'h5C, 1'b0, 8'h00, -1, 8'h00, w);
    checks++;
    if (w !== GAP) $display("FAIL b2b_gap_len: low cycles=%0d required %0d", w, GAP);
    else passes++;
    checks++;
    if (frames_out !== 8'd2) $display("FAIL b2b_frames: frames=%0d required 2", frames_out);
    else passes++;
  endtask

  task automatic test_mid_reset();
    int w;
    do_reset();
    data_in = 8'hA3;
    data_valid_in = 1'b1;
    w = 0;
    do begin
      @(negedge clock_1MHz);
      w++;
    end while (ack_out !== 1'b1 && w < 40);
    data_valid_in = 1'b0;
    repeat (3) @(negedge clock_1MHz);
    checks++;
    if (write_out !== 1'b1 || serial_out !== 1'b0)
      $display("FAIL midrst_bit3: write/serial=%b%b required 10", write_out, serial_out);
    else passes++;
    reset = 1'b0;
    @(negedge clock_1MHz);
    checks++;
    if ({ack_out, serial_out, write_out, busy_out, frames_out} !== 12'h000)
      $display("FAIL midrst_abort: ack/serial/write/busy=%b%b%b%b frames=%0d required 0000 0",
               ack_out, serial_out, write_out, busy_out, frames_out);
    else passes++;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock_1MHz);
      checks++;
      if (ack_out !== 1'b0 || write_out !== 1'b0 || busy_out !== 1'b0)
        $display("FAIL midrst_quiet: ack/write/busy=%b%b%b required 000", ack_out, write_out, busy_out);
      else passes++;
    end
    data_in = 8'h5C;
    data_valid_in = 1'b1;
    expect_frame("midrst_5c", 8'h5C, 1'b0, 8'h00, -1, 8'h00, w);
    checks++;
    if (frames_out !== 8'd1) $display("FAIL midrst_frames: frames=%0d required 1", frames_out);
    else passes++;
  endtask

  task automatic test_ignore_and_wrap();
    int w;
    int n;
    do_reset();
    data_in = 8'hA3;
    data_valid_in = 1'b1;
    expect_frame("ign_a3", 8'hA3, 1'b0, 8'h00, 2, 8'hFF, w);
    expect_frame("ign_ff", 8'hFF, 1'b1, 8'h55, -1, 8'h00, w);
    checks++;
    if (w !== GAP) $display("FAIL ign_capture_edge: wait=%0d required %0d", w, GAP);
    else passes++;
    checks++;
    if (frames_out !== 8'd2) $display("FAIL ign_frames: frames=%0d required 2", frames_out);
    else passes++;
    n = 0;
    while (frames_out !== 8'hFF && n < 4000) begin
      @(negedge clock_1MHz);
      n++;
    end
    checks++;
    if (frames_out !== 8'hFF) $display("FAIL wrap_reach255: frames=%0d required 255", frames_out);
    else passes++;
    n = 0;
    while (frames_out === 8'hFF && n < 40) begin
      @(negedge clock_1MHz);
      n++;
    end
    checks++;
    if (frames_out !== 8'd0) $display("FAIL wrap_zero: frames=%0d required 0", frames_out);
    else passes++;
    checks++;
    if (n !== FB + GAP) $display("FAIL wrap_period: period=%0d required %0d", n, FB + GAP);
    else passes++;
    data_valid_in = 1'b0;
  endtask

  task automatic test_parity();
    int w;
    do_reset();
    data_in = 8'hA3;
    data_valid_in = 1'b1;
    expect_frame("par_a3", 8'hA3, 1'b1, 8'h07, -1, 8'h00, w);
    expect_frame("par_07", 8'h07, 1'b0, 8'h00, -1, 8'h00, w);
    checks++;
    if (frames_out !== 8'd2) $display("FAIL par_frames: frames=%0d required 2", frames_out);
    else passes++;
  endtask

  initial begin
    reset = 1'b0;
    data_valid_in = 1'b0;
    data_in = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_mid_reset();
    test_ignore_and_wrap();
    test_parity();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
